// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared constants and response layout for the arbiter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int ADDR_W      = 15;
    localparam int DATA_W      = 16;
    localparam int MEM_LAT_DEF = 4;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    // Response entries are packed as {data, tag, id}, data in the MSBs.
    function automatic int resp_entry_w(input int tag_w, input int id_w);
        return DATA_W + tag_w + id_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | resp_fifo : first-word fall-through FIFO with occupancy count        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_o = (cnt_q != '0);
    assign pop_ok  = pop_i & valid_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter : round-robin sharing of one delayed memory port    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int TAG_W      = 4,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int RESP_DEPTH = 4,
    parameter int ID_W       = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    output logic [ADDR_W-1:0]        mem_raddr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_wen,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
);

    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int ENTRY_W = resp_entry_w(TAG_W, ID_W);

    logic [ID_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d, fifo_cnt;
    logic              credit_ok;
    logic [NREQ-1:0]   elig, grant;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;
    int                scan;
    op_e               sel_op;
    logic              load_gnt, store_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [TAG_W-1:0]  sel_tag;

    logic [ADDR_W-1:0] raddr_q, waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic [MEM_LAT:0]  pv_q;
    logic [TAG_W-1:0]  ptag_q [MEM_LAT+1];
    logic [ID_W-1:0]   pid_q  [MEM_LAT+1];

    logic               push;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    // Credits come only from registered counts, so a same-cycle pop frees nothing yet.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(RESP_DEPTH);
    assign elig      = req_valid & (req_we | {NREQ{credit_ok}}) & {NREQ{~reset}};

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        scan    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (int'(rr_q) + k) % NREQ;
            if (!gnt_any && elig[scan]) begin
                gnt_any     = 1'b1;
                grant[scan] = 1'b1;
                gnt_idx     = ID_W'(scan);
            end
        end
    end

    assign req_ready = grant;
    assign sel_op    = op_e'(req_we[gnt_idx]);
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_tag   = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
    assign load_gnt  = gnt_any & (sel_op == OP_LOAD);
    assign store_gnt = gnt_any & (sel_op == OP_STORE);

    assign push = pv_q[MEM_LAT];

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) rr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        inflight_d = inflight_q;
        case ({load_gnt, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            inflight_q <= '0;
            wen_q      <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            pv_q       <= '0;
        end else begin
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            wen_q      <= store_gnt;
            if (store_gnt) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (load_gnt) raddr_q <= sel_addr;
            pv_q <= {pv_q[MEM_LAT-1:0], load_gnt};
        end
    end

    // Tag/id travel alongside the valid bits; only the valids need clearing.
    always_ff @(posedge clk) begin
        ptag_q[0] <= sel_tag;
        pid_q[0]  <= gnt_idx;
        for (int s = 1; s <= MEM_LAT; s++) begin
            ptag_q[s] <= ptag_q[s-1];
            pid_q[s]  <= pid_q[s-1];
        end
    end

    assign mem_raddr = raddr_q;
    assign mem_wen   = wen_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;

    assign push_entry = {mem_rdata, ptag_q[MEM_LAT], pid_q[MEM_LAT]};

    resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (resp_ready),
        .valid_o     (resp_valid),
        .data_o      (head_entry),
        .count_o     (fifo_cnt)
    );

    assign {resp_data, resp_tag, resp_id} = head_entry;
    assign busy = (inflight_q != '0) | resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed and randomised checks of the arbiter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int NREQ = 4, TAG_W = 4, MEM_LAT = 4, RESP_DEPTH = 4, ID_W = 2;
    localparam int AW = 15, DW = 16, MSIZE = 32768;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0, req_ready, req_we = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic [AW-1:0]        mem_raddr, mem_waddr;
    logic [DW-1:0]        mem_rdata, mem_wdata, resp_data;
    logic                 mem_wen, resp_valid, busy;
    logic                 resp_ready = 1'b0;
    logic [TAG_W-1:0]     resp_tag;
    logic [ID_W-1:0]      resp_id;
    logic                 mem_init = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NREQ(NREQ), .TAG_W(TAG_W), .MEM_LAT(MEM_LAT), .RESP_DEPTH(RESP_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .resp_id(resp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 15'h0010) return 16'hBEEF;
        return {a, 1'b0} ^ 16'h5A5A;
    endfunction

    // Memory device: writes land at the clock edge, reads come back MEM_LAT cycles later.
    logic [DW-1:0] dev_mem [MSIZE];
    logic [DW-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MSIZE; i++) dev_mem[i] <= init_val(AW'(i));
        end else if (mem_wen) begin
            dev_mem[mem_waddr] <= mem_wdata;
        end
        rd_pipe[0] <= dev_mem[mem_raddr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Reference model: memory updated in grant order, expected responses in grant order.
    typedef struct packed {
        logic [DW-1:0]    d;
        logic [TAG_W-1:0] t;
        logic [ID_W-1:0]  id;
    } exp_t;

    exp_t          exp_q[$];
    int            gnt_log[$];
    logic [DW-1:0] ref_mem [MSIZE];
    int            outstanding = 0;
    int            max_out = 0;
    logic          exp_wen = 1'b0;
    logic [AW-1:0] exp_waddr = '0;
    logic [DW-1:0] exp_wdata = '0;

    always @(negedge clk) begin
        exp_t          e;
        logic [NREQ-1:0] g;
        logic [AW-1:0] a;
        if (mem_init)
            for (int i = 0; i < MSIZE; i++) ref_mem[i] = init_val(AW'(i));
        chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
        if (exp_wen) begin
            chk("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        end
        exp_wen = 1'b0;
        if (reset) begin
            exp_q.delete();
            outstanding = 0;
            chk("rst_ready", 32'(req_ready), 32'h0);
        end else begin
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", 32'(resp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp", 32'({resp_data, resp_tag, resp_id}), 32'(e));
                    outstanding--;
                end
            end
            g = req_valid & req_ready;
            chk("onehot", 32'($countones(req_ready) <= 1), 32'h1);
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    gnt_log.push_back(i);
                    a = req_addr[i*AW +: AW];
                    if (req_we[i]) begin
                        ref_mem[a] = req_wdata[i*DW +: DW];
                        exp_wen    = 1'b1;
                        exp_waddr  = a;
                        exp_wdata  = req_wdata[i*DW +: DW];
                    end else begin
                        exp_q.push_back({ref_mem[a], req_tag[i*TAG_W +: TAG_W], ID_W'(i)});
                        outstanding++;
                        if (outstanding > max_out) max_out = outstanding;
                        chk("credit", 32'(outstanding <= RESP_DEPTH), 32'h1);
                    end
                end
            end
        end
    end

    task automatic nc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [TAG_W-1:0] t);
        req_valid[i]            = v;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        nc();
        nc();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt, start;
        nc();
        nc();
        mem_init = 1'b0;

        // Reset state, with requests pending
        req_valid = 4'hF;
        smp();
        chk("rst_rdy",   32'(req_ready), 32'h0);
        chk("rst_wen",   32'(mem_wen), 32'h0);
        chk("rst_raddr", 32'(mem_raddr), 32'h0);
        chk("rst_waddr", 32'(mem_waddr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rvalid", 32'(resp_valid), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        nc();
        reset = 1'b0;
        req_valid = '0;

        // 1: single load from requester 2
        set_req(2, 1'b1, 1'b0, 15'h0010, 16'h0, 4'd5);
        smp(); chk("t1_grant", 32'(req_ready), 32'h4);
        nc(); req_valid = '0;
        smp();
        chk("t1_raddr", 32'(mem_raddr), 32'h10);
        chk("t1_wen", 32'(mem_wen), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int k = 2; k <= 5; k++) begin
            nc(); smp(); chk("t1_early", 32'(resp_valid), 32'h0);
        end
        nc(); resp_ready = 1'b1; smp();
        chk("t1_rvalid", 32'(resp_valid), 32'h1);
        chk("t1_data", 32'(resp_data), 32'hBEEF);
        chk("t1_tag", 32'(resp_tag), 32'h5);
        chk("t1_id", 32'(resp_id), 32'h2);
        nc(); resp_ready = 1'b0; smp();
        chk("t1_empty", 32'(resp_valid), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);

        // 2: store then load to the same address
        nc(); set_req(0, 1'b1, 1'b1, 15'h0020, 16'h1234, 4'd0);
        smp(); chk("t2_g0", 32'(req_ready), 32'h1);
        nc(); req_valid = '0; set_req(1, 1'b1, 1'b0, 15'h0020, 16'h0, 4'hA);
        smp();
        chk("t2_wen", 32'(mem_wen), 32'h1);
        chk("t2_waddr", 32'(mem_waddr), 32'h20);
        chk("t2_wdata", 32'(mem_wdata), 32'h1234);
        chk("t2_g1", 32'(req_ready), 32'h2);
        nc(); req_valid = '0; smp();
        chk("t2_wen_off", 32'(mem_wen), 32'h0);
        chk("t2_raddr", 32'(mem_raddr), 32'h20);
        chk("t2_whold", 32'(mem_wdata), 32'h1234);
        repeat (4) nc();
        smp(); chk("t2_early", 32'(resp_valid), 32'h0);
        nc(); resp_ready = 1'b1; smp();
        chk("t2_rvalid", 32'(resp_valid), 32'h1);
        chk("t2_data", 32'(resp_data), 32'h1234);
        chk("t2_id", 32'(resp_id), 32'h1);
        chk("t2_tag", 32'(resp_tag), 32'hA);
        nc(); resp_ready = 1'b0;

        // 3: all requesters stream loads
        do_reset();
        start = gnt_log.size();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(15'h40 + i), 16'h0, TAG_W'(i + 8));
        resp_ready = 1'b1;
        repeat (24) begin smp(); nc(); end
        req_valid = '0;
        repeat (12) nc();
        smp();
        chk("t3_count", 32'(gnt_log.size() - start >= 8), 32'h1);
        for (int j = 0; j < 8; j++) chk("t3_order", 32'(gnt_log[start + j]), 32'(j % 4));
        chk("t3_idle", 32'(busy), 32'h0);

        // 4: credit exhaustion with the consumer stalled
        nc(); do_reset();
        set_req(0, 1'b1, 1'b0, 15'h0050, 16'h0, 4'd3);
        resp_ready = 1'b0;
        cnt = 0;
        repeat (12) begin smp(); if (req_ready[0]) cnt++; nc(); end
        chk("t4_grants", 32'(cnt), 32'h4);
        set_req(1, 1'b1, 1'b1, 15'h0051, 16'h1111, 4'd0);
        set_req(3, 1'b1, 1'b1, 15'h0053, 16'h3333, 4'd0);
        smp(); chk("t4_st1", 32'(req_ready), 32'h2);
        nc(); smp(); chk("t4_st3", 32'(req_ready), 32'h8);
        nc(); req_valid[1] = 1'b0; req_valid[3] = 1'b0; resp_ready = 1'b1;
        smp();
        chk("t4_pop_nofree", 32'(req_ready), 32'h0);
        chk("t4_full", 32'(resp_valid), 32'h1);
        nc(); resp_ready = 1'b0; smp();
        chk("t4_freed", 32'(req_ready), 32'h1);
        nc(); smp();
        chk("t4_refull", 32'(req_ready), 32'h0);
        nc(); req_valid = '0; resp_ready = 1'b1;
        repeat (12) nc();
        smp(); chk("t4_idle", 32'(busy), 32'h0);

        // 5: random mixed traffic with random back-pressure
        nc(); do_reset();
        repeat (1000) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom % 2), 1'($urandom % 2), AW'(15'h100 + ($urandom % 8)),
                        16'($urandom), 4'($urandom));
            resp_ready = (($urandom % 4) != 0);
            nc();
        end
        req_valid = '0; resp_ready = 1'b1;
        repeat (20) nc();
        smp();
        chk("t5_drained", 32'(exp_q.size()), 32'h0);
        chk("t5_idle", 32'(busy), 32'h0);
        chk("t5_maxout", 32'(max_out <= RESP_DEPTH), 32'h1);

        // 6: reset with loads in flight
        nc(); do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, AW'(15'h60 + i), 16'h0, TAG_W'(i + 1));
        cnt = 0;
        repeat (3) begin smp(); if (req_ready != '0) cnt++; nc(); end
        chk("t6_issued", 32'(cnt), 32'h3);
        reset = 1'b1; req_valid = 4'hF; resp_ready = 1'b1;
        smp(); chk("t6_rst_rdy", 32'(req_ready), 32'h0);
        nc(); nc();
        reset = 1'b0; req_valid = '0;
        cnt = 0;
        smp(); chk("t6_busy0", 32'(busy), 32'h0);
        repeat (8) begin if (resp_valid) cnt++; nc(); smp(); end
        chk("t6_noresp", 32'(cnt), 32'h0);
        nc(); resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(15'h70 + i), 16'h0, 4'd9);
        smp(); chk("t6_rr0", 32'(req_ready), 32'h1);
        nc(); req_valid = '0;
        repeat (4) nc();
        smp(); chk("t6_early", 32'(resp_valid), 32'h0);
        nc(); resp_ready = 1'b1; smp();
        chk("t6_rvalid", 32'(resp_valid), 32'h1);
        chk("t6_id", 32'(resp_id), 32'h0);
        chk("t6_data", 32'(resp_data), 32'(init_val(15'h70)));
        nc(); resp_ready = 1'b0;
        repeat (3) nc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single long-latency data port of the main memory (delayed read port plus write port) between NREQ load/store requesters, e.g. load queue, store buffer and debug/loader.
- Issues at most one operation per cycle using round-robin arbitration.
- Tracks in-flight loads in a tag pipeline matched to the fixed memory read latency, and returns load data, with tag and requester id, through a response FIFO.
- Credit logic guarantees the non-stallable memory pipeline can never overflow the FIFO.

Parameters:
NREQ, 4, number of requesters
TAG_W, 4, requester-supplied tag width, returned unchanged with load data
MEM_LAT, 4, cycles from address presentation on mem_raddr to data valid on mem_rdata (memory DELAY=2, plus 2)
RESP_DEPTH, 4, response FIFO entries; also the maximum number of outstanding loads
ID_W, $clog2(NREQ), requester id width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant; handshake when valid&ready
req_we  in  NREQ  1=store, 0=load
req_addr  in  NREQ*15  halfword address [15:1], requester i at bits [15i+14:15i]
req_wdata  in  NREQ*16  store data
req_tag  in  NREQ*TAG_W  load tag
mem_raddr  out  15  to memory delayed read address
mem_rdata  in  16  from memory delayed read data
mem_wen  out  1  memory write enable
mem_waddr  out  15  memory write address
mem_wdata  out  16  memory write data
resp_valid  out  1  load response available
resp_ready  in  1  consumer accepts response
resp_data  out  16  load data
resp_tag  out  TAG_W  tag of the load
resp_id  out  ID_W  requester index of the load
busy  out  1  any load in flight or response pending

Behaviour:
- Eligibility:
  - Store: eligible whenever req_valid.
  - Load: eligible iff req_valid and (inflight_cnt + fifo_cnt) < RESP_DEPTH.
  - Both counts are registered values. A FIFO pop in the same cycle does not free a credit until the next cycle.
- Arbitration:
  - Round-robin pointer rr (reset 0). Grant the first eligible index scanning rr, rr+1, … mod NREQ.
  - req_ready is combinational and one-hot or zero.
  - After a grant to index g, rr <= (g+1) mod NREQ; otherwise rr holds.
- Issue:
  - Grant in cycle T: memory outputs are registered and driven in cycle T+1.
  - Store: mem_wen=1 with mem_waddr/mem_wdata for exactly one cycle.
  - Load: mem_raddr=addr; mem_wen=0.
  - mem_raddr and mem_waddr/mem_wdata hold their last values when idle.
  - Reset values: mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
- Ordering:
  - Read and write paths have equal internal delay, so issue order equals memory order.
  - A load granted after a store to the same address returns the new data. No address hazard check.
- Tag pipeline:
  - MEM_LAT+1 stages of {valid, tag, id}. Stage 0 is loaded alongside the mem_raddr register; the pipeline advances every cycle and never stalls.
  - When the last stage is valid, mem_rdata is captured into the FIFO with its tag/id at the end of cycle T+1+MEM_LAT.
  - Result: resp_valid is asserted in cycle T+2+MEM_LAT (T+6 at defaults).
- Response FIFO:
  - RESP_DEPTH entries, first-word fall-through.
  - resp_valid = not empty; pop on resp_valid & resp_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by credit; the bench asserts this.
- inflight_cnt:
  - +1 on load grant, −1 on pipeline exit; both in the same cycle leaves it unchanged.
  - Range 0..RESP_DEPTH.
- busy = (inflight_cnt != 0) | resp_valid.
- Reset, including mid-operation:
  - Clears rr, counts, FIFO pointers, all pipeline valid bits, mem_wen, and the memory address/data registers.
  - In-flight loads are discarded with no response.
  - A store already driven before reset still commits in memory; memory itself is not reset.
  - req_ready=0 during reset.

Decomposition:
- Package mem_arb_pkg holds ADDR_W=15, DATA_W=16, the default MEM_LAT, and the response entry layout {data, tag, id}.
- One sub-module: resp_fifo (parameterised depth/width, FWFT, count output).
- Arbiter, credit logic and tag pipeline stay in mem_port_arbiter.

Test Plan:
1. Single load, requester 2, addr 0x0010 holding 0xBEEF, tag 5, granted T → resp_valid at T+6 with data 0xBEEF, tag 5, id 2; busy falls after pop.
2. Store 0x1234 to 0x0020 by req 0 at T, load 0x0020 by req 1 at T+1 → mem_wen pulses in T+1 only; load response data 0x1234.
3. All 4 requesters issue loads continuously → grants in order 0,1,2,3,0…; responses return in grant order with matching ids/tags.
4. resp_ready=0, req 0 streams loads → exactly 4 grants, then req_ready[0]=0 while other requesters' stores keep being granted; one pop frees exactly one load grant, made the following cycle.
5. Mixed stores and loads with random resp_ready over 1000 cycles → FIFO never overflows, every load returns exactly once, and data matches a reference memory model.
6. Reset asserted with 3 loads in flight → no response emerges afterwards, counts read 0, rr=0, and first post-reset load response arrives at grant+6.
